// File: rtl/instr_register_pkg.sv
// Shared instruction register types plus the reader FSM state encoding.
// Operands are unsigned; results wrap to the result field width.
package instr_register_pkg;

    localparam int IR_DEPTH = 32;

    typedef enum logic [3:0] {
        ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD, POW
    } opcode_t;

    typedef logic [7:0]                   operand_t;
    typedef logic [15:0]                  result_t;
    typedef logic [$clog2(IR_DEPTH)-1:0]  address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  res;
    } instruction_t;

    typedef enum logic [1:0] {
        IDLE, FETCH, DRAIN, FIN
    } reader_state_t;

endpackage

// File: rtl/instr_reader_if.sv
// Command, register read port and consumer handshake of the instruction reader.
// The master modport is the reader; the slave modport is its environment.
interface instr_reader_if #(
    parameter int ADDR_W = 5
);
    import instr_register_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] start_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] read_pointer;
    instruction_t      instruction_word;
    logic              out_valid;
    logic              out_ready;
    instruction_t      out_instr;
    logic              out_mismatch;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   err_count;

    modport master (
        input  start, start_ptr, count,
        input  instruction_word, out_ready,
        output read_pointer, out_valid,
        output out_instr, out_mismatch,
        output busy, done, err_count
    );

    modport slave (
        output start, start_ptr, count,
        output instruction_word, out_ready,
        input  read_pointer, out_valid,
        input  out_instr, out_mismatch,
        input  busy, done, err_count
    );

endinterface

// File: rtl/instr_result_model.sv
// Combinational golden result for one instruction's operands.
// known_o is low for opcodes outside the table, which suppresses checking.
module instr_result_model
    import instr_register_pkg::*;
(
    input  opcode_t  opcode_i,
    input  operand_t op_a_i,
    input  operand_t op_b_i,
    output result_t  result_o,
    output logic     known_o
);

    result_t a, b, base, pw;

    always_comb begin
        a    = result_t'(op_a_i);
        b    = result_t'(op_b_i);
        base = a;
        pw   = 16'd1;
        // square-and-multiply keeps POW to 8 stages; wraps mod 2^16
        for (int i = 0; i < 8; i++) begin
            if (op_b_i[i]) pw = pw * base;
            base = base * base;
        end
        result_o = '0;
        known_o  = 1'b1;
        unique case (opcode_i)
            ZERO:    result_o = '0;
            PASSA:   result_o = a;
            PASSB:   result_o = b;
            ADD:     result_o = a + b;
            SUB:     result_o = a - b;
            MULT:    result_o = a * b;
            DIV:     result_o = (b == '0) ? '0 : a / b;
            MOD:     result_o = (b == '0) ? '0 : a % b;
            POW:     result_o = (b == '0) ? 16'd1 : pw;
            default: known_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_reader.sv
// Walks read_pointer over a commanded window, registers each word for a
// valid/ready consumer and flags words whose stored result disagrees.
module instr_reader
    import instr_register_pkg::*;
#(
    parameter int DEPTH    = IR_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter bit CHECK_EN = 1'b1
) (
    input  logic           clk,
    input  logic           reset_n,
    instr_reader_if.master bus
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

    reader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] rp_q, rp_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [ADDR_W:0]   err_q, err_d;
    logic              ov_q, ov_d;
    logic              mm_q, mm_d;
    instruction_t      instr_q, instr_d;

    result_t         gold;
    logic            known;
    logic            check;
    logic            load;
    logic            accept;
    logic [ADDR_W:0] cnt_sat;

    instr_result_model u_model (
        .opcode_i (bus.instruction_word.opc),
        .op_a_i   (bus.instruction_word.op_a),
        .op_b_i   (bus.instruction_word.op_b),
        .result_o (gold),
        .known_o  (known)
    );

    assign check   = CHECK_EN && known
                   && (bus.instruction_word.res != gold);
    assign cnt_sat = (bus.count > DEPTH_C) ? DEPTH_C : bus.count;
    assign accept  = ov_q & bus.out_ready;
    assign load    = (state_q == FETCH) & (~ov_q | bus.out_ready);

    always_comb begin
        state_d = state_q;
        rp_d    = rp_q;
        rem_d   = rem_q;
        err_d   = err_q;
        ov_d    = ov_q;
        mm_d    = mm_q;
        instr_d = instr_q;
        if (accept && mm_q && (err_q != '1))
            err_d = err_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rp_d    = bus.start_ptr;
                    rem_d   = cnt_sat;
                    err_d   = '0;
                    state_d = (bus.count != '0) ? FETCH : FIN;
                end
            end
            FETCH: begin
                if (load) begin
                    instr_d = bus.instruction_word;
                    mm_d    = check;
                    ov_d    = 1'b1;
                    rp_d    = (rp_q == LAST_C) ? '0 : rp_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    if (rem_q == 1) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (accept) begin
                    ov_d    = 1'b0;
                    state_d = FIN;
                end
            end
            FIN: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rp_q    <= '0;
            rem_q   <= '0;
            err_q   <= '0;
            ov_q    <= 1'b0;
            mm_q    <= 1'b0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            rp_q    <= rp_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            ov_q    <= ov_d;
            mm_q    <= mm_d;
            instr_q <= instr_d;
        end
    end

    assign bus.read_pointer = rp_q;
    assign bus.out_valid    = ov_q;
    assign bus.out_instr    = instr_q;
    assign bus.out_mismatch = mm_q;
    assign bus.err_count    = err_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = (state_q == FIN);

endmodule

// File: tb/tb_instr_reader.sv
// Randomised scoreboard bench for instr_reader with a behavioural
// register-window model and an independent golden arithmetic function.
module tb_instr_reader;
    import instr_register_pkg::*;

    localparam int D  = IR_DEPTH;
    localparam int AW = $clog2(D);

    typedef struct {
        instruction_t ins;
        logic         mm;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    instr_reader_if #(.ADDR_W(AW)) bus ();

    instr_reader #(.DEPTH(D), .ADDR_W(AW), .CHECK_EN(1'b1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    instruction_t mem [D];
    assign bus.instruction_word = mem[bus.read_pointer];

    exp_t sb [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   acc_n, first_acc, last_acc, start_cyc;
    int   cmd_words, done_n, err_exp;
    bit   full_rate;
    int   rdy_mode = 0;
    int   rdy_low = 0;
    bit   stall = 1'b0;
    instruction_t hold_ins;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // returns {known, result}
    function automatic logic [16:0] gold(instruction_t w);
        int unsigned a, b, r;
        a = 32'(w.op_a);
        b = 32'(w.op_b);
        case (w.opc)
            ZERO:  r = 0;
            PASSA: r = a;
            PASSB: r = b;
            ADD:   r = a + b;
            SUB:   r = a - b;
            MULT:  r = a * b;
            DIV:   r = (b == 0) ? 0 : a / b;
            MOD:   r = (b == 0) ? 0 : a % b;
            POW: begin
                r = 1;
                for (int i = 0; i < int'(b); i++) r = (r * a) % 65536;
            end
            default: return 17'h0;
        endcase
        return {1'b1, r[15:0]};
    endfunction

    function automatic instruction_t mk(int op, int a, int b, int res);
        instruction_t w;
        w.opc  = opcode_t'(op[3:0]);
        w.op_a = a[7:0];
        w.op_b = b[7:0];
        w.res  = res[15:0];
        return w;
    endfunction

    task automatic fill_random();
        logic [16:0] g;
        for (int i = 0; i < D; i++) begin
            mem[i] = mk($urandom_range(11), $urandom_range(255),
                        ($urandom_range(3) == 0) ? 0 : $urandom_range(12),
                        $urandom_range(65535));
            g = gold(mem[i]);
            if ($urandom_range(1) == 1) mem[i].res = g[15:0];
        end
    endtask

    task automatic push_cmd(int sp, int cnt);
        exp_t        e;
        logic [16:0] g;
        int          n;
        n = (cnt > D) ? D : cnt;
        sb.delete();
        for (int i = 0; i < n; i++) begin
            e.ins = mem[(sp + i) % D];
            g     = gold(e.ins);
            e.mm  = g[16] && (g[15:0] != e.ins.res);
            sb.push_back(e);
        end
        cmd_words = n;
        acc_n     = 0;
        err_exp   = 0;
        done_n    = 0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rdy_low > 0) begin
            bus.out_ready = 1'b0;
            rdy_low--;
        end else begin
            bus.out_ready = (rdy_mode == 0) ? 1'b1
                          : ($urandom_range(3) != 0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("hold_valid", 64'(bus.out_valid), 64'd1);
                chk("hold_instr", 64'(bus.out_instr), 64'(hold_ins));
            end
            stall    = bus.out_valid && !bus.out_ready;
            hold_ins = bus.out_instr;
            if (bus.out_valid && bus.out_ready) begin
                chk("word_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("out_instr", 64'(bus.out_instr), 64'(e.ins));
                    chk("out_mismatch", 64'(bus.out_mismatch), 64'(e.mm));
                    if (e.mm && err_exp < 63) err_exp++;
                end
                if (acc_n == 0) first_acc = cyc;
                last_acc = cyc;
                acc_n++;
            end
            if (bus.done) begin
                done_n++;
                chk("words_left", 64'(sb.size()), 64'd0);
                chk("acc_total", 64'(acc_n), 64'(cmd_words));
                chk("err_count", 64'(bus.err_count), 64'(err_exp));
                if (cmd_words > 0)
                    chk("done_lat", 64'(cyc - last_acc), 64'd1);
                else
                    chk("done_lat0", 64'((cyc - start_cyc) >= 1
                        && (cyc - start_cyc) <= 2), 64'd1);
                if (full_rate && cmd_words > 0) begin
                    chk("first_lat", 64'(first_acc - start_cyc), 64'd2);
                    chk("rate", 64'(last_acc - first_acc),
                        64'(cmd_words - 1));
                end
            end
        end
    end

    // caller is positioned at posedge+1
    task automatic run_cmd(int sp, int cnt, bit fr, bit poke, bit stall3);
        int t;
        rdy_mode  = fr ? 0 : 1;
        full_rate = fr && !stall3;
        push_cmd(sp, cnt);
        bus.start_ptr = sp[AW-1:0];
        bus.count     = cnt[AW:0];
        bus.start     = 1'b1;
        start_cyc     = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (poke) begin
            repeat (2) @(posedge clk);
            #1;
            bus.start_ptr = AW'($urandom_range(D - 1));
            bus.count     = (AW+1)'($urandom_range(D, 1));
            bus.start     = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        if (stall3) begin
            t = 0;
            while (acc_n == 0 && t < 50) begin @(negedge clk); t++; end
            rdy_low = 3;
        end
        t = 0;
        while (done_n == 0 && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        chk("done_seen", 64'(done_n), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("done_once", 64'(done_n), 64'd1);
        chk("idle_after", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int t;
        bus.start     = 1'b0;
        bus.start_ptr = '0;
        bus.count     = '0;
        fill_random();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_err", 64'(bus.err_count), 64'd0);
        chk("rst_ptr", 64'(bus.read_pointer), 64'd0);
        chk("rst_instr", 64'(bus.out_instr), 64'd0);

        mem[0] = mk(ADD, 5, 3, 8);
        mem[1] = mk(SUB, 5, 3, 2);
        mem[2] = mk(MULT, 4, 6, 24);
        mem[3] = mk(DIV, 9, 0, 0);
        run_cmd(0, 4, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < D; i++) mem[i] = mk(ADD, i, 1, i + 1);
        run_cmd(30, 4, 1'b1, 1'b0, 1'b0);

        fill_random();
        run_cmd(5, 10, 1'b1, 1'b0, 1'b1);

        mem[0] = mk(ADD, 2, 2, 4);
        mem[1] = mk(PASSA, 7, 1, 7);
        mem[2] = mk(ADD, 1, 1, 99);
        mem[3] = mk(POW, 2, 3, 8);
        run_cmd(0, 4, 1'b1, 1'b0, 1'b0);

        fill_random();
        run_cmd(7, 0, 1'b1, 1'b0, 1'b0);
        run_cmd(3, 40, 1'b1, 1'b0, 1'b0);
        run_cmd(10, 20, 1'b0, 1'b1, 1'b0);

        // reset while the second of four words is presented
        fill_random();
        rdy_mode = 0;
        push_cmd(0, 4);
        bus.start_ptr = '0;
        bus.count     = (AW+1)'(4);
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        t = 0;
        while (acc_n == 0 && t < 20) begin @(posedge clk); #1; t++; end
        chk("first_word_seen", 64'(acc_n), 64'd1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        sb.delete();
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_err", 64'(bus.err_count), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("mid_rst_no_done", 64'(done_n), 64'd0);
        run_cmd(1, 6, 1'b1, 1'b0, 1'b0);

        for (int k = 0; k < 15; k++) begin
            fill_random();
            run_cmd($urandom_range(D - 1), $urandom_range(40),
                    $urandom_range(1), 1'b0, $urandom_range(1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
